imm_gen_pipe: RTL and testbench

//  Registered, XLEN-parametrised immediate generator for the ID stage. Decodes every RV32I/RV64I

---
 rtl/imm_gen_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// imm_gen_pipe
//   Registered immediate generator for the ID stage. Decodes the RV32I/RV64I
//   immediate formats (I, S, B, U, J and the CSR zimm) from the incoming
//   instruction and stores the result, together with the instruction and its
//   PC, in a 2-entry skid buffer.
//
//   Handshake: a beat transfers on the input side when in_valid & in_ready at
//   a rising clk edge, and on the output side when out_valid & out_ready. A
//   producer may not withdraw or change a beat while valid is high and ready
//   is low. out_* stay stable until they are consumed.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         drops every buffered entry and any same-cycle input
//   in_valid      in_instr/in_pc carry a beat
//   in_ready      buffer can take a beat (registered)
//   in_instr      32-bit instruction word
//   in_pc         PC of the instruction
//   out_valid     out_* carry a beat
//   out_ready     downstream takes the beat
//   out_instr     instruction passed through
//   out_pc        PC passed through
//   out_imm       decoded immediate, XLEN bits
//   out_fmt       0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
//   out_illegal   opcode not recognised
//   state_dbg     buffer occupancy state (0 EMPTY, 1 HALF, 2 FULL)
// ============================================================================
module imm_gen_pipe #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal,
   output logic [1:0]      state_dbg
);

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_Z    = 3'd6;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
   } entry_t;

   state_t state;
   entry_t head;   // drives out_*
   entry_t skid;   // second entry, only meaningful in FULL
   entry_t dec;    // decoded form of the current input

   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_ill;
   logic            accept;
   logic            pop;

   // ---------------------------------------------------------------------
   // Combinational decode. The immediate is first filled with the sign bit
   // and then the low bits are overwritten, which sign-extends to any XLEN.
   // ---------------------------------------------------------------------
   always_comb begin
      dec_imm = '0;
      dec_fmt = FMT_NONE;
      dec_ill = 1'b0;
      case (in_instr[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
            dec_imm        = {XLEN{in_instr[31]}};
            dec_imm[11:0]  = in_instr[31:20];
            dec_fmt        = FMT_I;
         end
         7'b0011011: begin
            if (XLEN == 64) begin
               dec_imm       = {XLEN{in_instr[31]}};
               dec_imm[11:0] = in_instr[31:20];
               dec_fmt       = FMT_I;
            end else begin
               dec_ill = 1'b1;
            end
         end
         7'b0100011: begin
            dec_imm       = {XLEN{in_instr[31]}};
            dec_imm[11:0] = {in_instr[31:25], in_instr[11:7]};
            dec_fmt       = FMT_S;
         end
         7'b1100011: begin
            dec_imm       = {XLEN{in_instr[31]}};
            dec_imm[12:0] = {in_instr[31], in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
            dec_fmt       = FMT_B;
         end
         7'b0110111, 7'b0010111: begin
            dec_imm       = {XLEN{in_instr[31]}};
            dec_imm[31:0] = {in_instr[31:12], 12'b0};
            dec_fmt       = FMT_U;
         end
         7'b1101111: begin
            dec_imm       = {XLEN{in_instr[31]}};
            dec_imm[20:0] = {in_instr[31], in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
            dec_fmt       = FMT_J;
         end
         7'b1110011: begin
            // Only the CSR*I forms (funct3[2]=1) carry a zimm.
            if (in_instr[14]) begin
               dec_imm[4:0] = in_instr[19:15];
               dec_fmt      = FMT_Z;
            end
         end
         7'b0110011: begin
         end
         7'b0111011: begin
            if (XLEN != 64) dec_ill = 1'b1;
         end
         default: dec_ill = 1'b1;
      endcase
   end

   always_comb begin
      dec.instr   = in_instr;
      dec.pc      = in_pc;
      dec.imm     = dec_imm;
      dec.fmt     = dec_fmt;
      dec.illegal = dec_ill;
   end

   // A flush discards the same-cycle input.
   assign accept = in_valid & in_ready & ~flush;
   assign pop    = out_valid & out_ready;

   // ---------------------------------------------------------------------
   // Skid buffer FSM. in_ready is the registered image of (next != FULL).
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         head      <= '0;
         skid      <= '0;
      end else if (flush) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  head      <= dec;
                  out_valid <= 1'b1;
                  state     <= HALF;
               end
            end
            HALF: begin
               if (accept && !pop) begin
                  skid     <= dec;
                  state    <= FULL;
                  in_ready <= 1'b0;
               end else if (pop && !accept) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end else if (pop && accept) begin
                  // Head leaves, new entry takes its place: 1 beat/clk.
                  head <= dec;
               end
            end
            FULL: begin
               if (pop) begin
                  head     <= skid;
                  state    <= HALF;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign out_instr   = head.instr;
   assign out_pc      = head.pc;
   assign out_imm     = head.imm;
   assign out_fmt     = head.fmt;
   assign out_illegal = head.illegal;
   assign state_dbg   = state;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

   // ------------------------------------------------------------------
   // Clock / reset and DUT hookup
   // ------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;

   logic        in_ready, out_valid, out_illegal;
   logic [31:0] out_instr, out_pc, out_imm;
   logic [2:0]  out_fmt;
   logic [1:0]  state_dbg;

   logic        in_ready64, out_valid64, out_illegal64;
   logic [31:0] out_instr64;
   logic [63:0] out_pc64, out_imm64;
   logic [2:0]  out_fmt64;
   logic [1:0]  state_dbg64;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm),
      .out_fmt(out_fmt), .out_illegal(out_illegal), .state_dbg(state_dbg)
   );

   imm_gen_pipe #(.XLEN(64)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_pc({32'b0, in_pc}),
      .out_valid(out_valid64), .out_ready(out_ready),
      .out_instr(out_instr64), .out_pc(out_pc64), .out_imm(out_imm64),
      .out_fmt(out_fmt64), .out_illegal(out_illegal64), .state_dbg(state_dbg64)
   );

   // ------------------------------------------------------------------
   // Checking and scoreboard
   // ------------------------------------------------------------------
   int passed = 0;
   int total  = 0;
   logic [99:0] exp_q[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference decode for XLEN=32: returns {imm, fmt, illegal}.
   function automatic logic [35:0] model(input logic [31:0] i);
      logic signed [31:0] t;
      logic [31:0] imm;
      logic [2:0]  f;
      logic        ill;
      imm = '0; f = 3'd0; ill = 1'b0;
      case (i[6:0])
         7'h03, 7'h13, 7'h67, 7'h0F: begin t = i; t = t >>> 20; imm = t; f = 3'd1; end
         7'h23: begin t = {i[31:25], i[11:7], 20'b0}; t = t >>> 20; imm = t; f = 3'd2; end
         7'h63: begin
            t = {i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0}; t = t >>> 19; imm = t; f = 3'd3;
         end
         7'h37, 7'h17: begin imm = i & 32'hFFFF_F000; f = 3'd4; end
         7'h6F: begin
            t = {i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0}; t = t >>> 11; imm = t; f = 3'd5;
         end
         7'h73: if (i[14]) begin imm = {27'b0, i[19:15]}; f = 3'd6; end
         7'h33: ;
         default: ill = 1'b1;
      endcase
      return {imm, f, ill};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [16];
      logic [31:0] r;
      ops = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h1B, 7'h23, 7'h63, 7'h37,
              7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B, 7'h00, 7'h7F, 7'h0B};
      r = $urandom;
      if ($urandom_range(0, 7) == 0) return r;
      return {r[31:7], ops[$urandom_range(0, 15)]};
   endfunction

   // Directed decode vectors: instr, imm (32), fmt, illegal, fmt/illegal on XLEN=64.
   logic [31:0] v_instr [14] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'hFFDFF06F,
                                 32'h800000B7, 32'h0000001B, 32'h00B50533, 32'hFFFFD073,
                                 32'h00000073, 32'h00000000, 32'h00001097, 32'h7FF02083,
                                 32'hFFF00067, 32'h0FF0000F};
   logic [31:0] v_imm   [14] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFFC,
                                 32'h80000000, 32'h00000000, 32'h00000000, 32'h0000001F,
                                 32'h00000000, 32'h00000000, 32'h00001000, 32'h000007FF,
                                 32'hFFFFFFFF, 32'h000000FF};
   logic [2:0]  v_fmt   [14] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd0, 3'd0, 3'd6,
                                 3'd0, 3'd0, 3'd4, 3'd1, 3'd1, 3'd1};
   logic        v_ill   [14] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
   logic [2:0]  v_fmt64 [14] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd1, 3'd0, 3'd6,
                                 3'd0, 3'd0, 3'd4, 3'd1, 3'd1, 3'd1};
   logic        v_ill64 [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

   initial begin
      logic [35:0] m;
      logic [99:0] e;
      int sent;
      int cycles;

      // ---- reset state ----
      tick(); tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_imm", out_imm, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_fmt", out_fmt, 0);
      chk("rst_out_illegal", out_illegal, 0);
      rst_n = 1'b1;
      tick();

      // ---- directed decode, streamed back to back ----
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = v_instr[0];
      in_pc     = 32'h1000;
      chk("lat_before", out_valid, 0);
      for (int k = 0; k < 14; k++) begin
         in_instr = v_instr[k];
         in_pc    = 32'h1000 + 32'(4 * k);
         tick();
         chk($sformatf("dec%0d_valid", k), out_valid, 1);
         chk($sformatf("dec%0d_imm", k), out_imm, v_imm[k]);
         chk($sformatf("dec%0d_fmt", k), out_fmt, v_fmt[k]);
         chk($sformatf("dec%0d_ill", k), out_illegal, v_ill[k]);
         chk($sformatf("dec%0d_instr", k), out_instr, v_instr[k]);
         chk($sformatf("dec%0d_pc", k), out_pc, 32'h1000 + 32'(4 * k));
         chk($sformatf("dec%0d_imm64", k), out_imm64, {{32{v_imm[k][31]}}, v_imm[k]});
         chk($sformatf("dec%0d_fmt64", k), out_fmt64, v_fmt64[k]);
         chk($sformatf("dec%0d_ill64", k), out_illegal64, v_ill64[k]);
      end
      in_valid = 1'b0;
      tick();
      chk("drain_valid", out_valid, 0);

      // ---- stall: fill to FULL, then release ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h00100093; in_pc = 32'h200;
      tick();
      chk("stall1_valid", out_valid, 1);
      chk("stall1_ready", in_ready, 1);
      in_instr = 32'h00200113; in_pc = 32'h204;
      tick();
      chk("stall2_ready", in_ready, 0);
      chk("stall2_state", state_dbg, 2);
      chk("stall2_pc", out_pc, 32'h200);
      in_instr = 32'h00300193; in_pc = 32'h208;
      tick();
      chk("stall3_ready", in_ready, 0);
      chk("stall3_pc", out_pc, 32'h200);
      chk("stall3_imm", out_imm, 32'h1);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      tick();
      chk("rel1_valid", out_valid, 1);
      chk("rel1_pc", out_pc, 32'h204);
      chk("rel1_imm", out_imm, 32'h2);
      chk("rel1_ready", in_ready, 1);
      tick();
      chk("rel2_valid", out_valid, 0);

      // ---- flush on a FULL buffer with a same-cycle input ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h00400213; in_pc = 32'h300;
      tick();
      in_instr = 32'h00500293; in_pc = 32'h304;
      tick();
      chk("prefl_ready", in_ready, 0);
      flush    = 1'b1;
      in_instr = 32'h00600313; in_pc = 32'h308;
      tick();
      chk("fl_valid", out_valid, 0);
      chk("fl_ready", in_ready, 1);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("fl_after_valid", out_valid, 0);

      // ---- asynchronous reset while HALF ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFFF00093; in_pc = 32'h400;
      tick();
      in_valid = 1'b0;
      chk("arst_pre_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_imm", out_imm, 0);
      chk("arst_pc", out_pc, 0);
      chk("arst_ready", in_ready, 1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("arst_after_valid", out_valid, 0);

      // ---- random stream against the reference model ----
      sent   = 0;
      cycles = 0;
      while ((sent < 1000 || exp_q.size() != 0) && cycles < 20000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (sent < 1000 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_instr = rand_instr();
            in_pc    = $urandom;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("rand_extra", out_valid, 0);
            else begin
               e = exp_q.pop_front();
               chk("rand_entry", {out_instr, out_pc, out_imm, out_fmt, out_illegal}, e);
            end
         end
         if (in_valid && in_ready) begin
            m = model(in_instr);
            exp_q.push_back({in_instr, in_pc, m});
            sent++;
         end
         tick();
         cycles++;
      end
      chk("rand_sent", sent, 1000);
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_final_valid", out_valid, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
